// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the memory access unit.
// Revision 1.0 - initial release.
`default_nettype none

package mem_access_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  localparam int TIMEOUT_CYCLES = 16;

  // Raw loadsize: bit1 dominates (word), then bit0 (half), else byte.
  function automatic size_t decode_size(input logic [1:0] ls);
    if (ls[1])      return SZ_WORD;
    else if (ls[0]) return SZ_HALF;
    else            return SZ_BYTE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores and loads, plus misalignment detect.
// Revision 1.0 - initial release.
`default_nettype none

module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  i_req_off,
  input  size_t       i_req_size,
  input  logic [31:0] i_bdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  input  logic [1:0]  i_rsp_off,
  input  size_t       i_rsp_size,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_rsh;

  assign o_wdata = i_bdata << {i_req_off, 3'b000};
  assign w_rsh   = i_rdata >> {i_rsp_off, 3'b000};

  always_comb begin
    o_be       = 4'b0001 << i_req_off;
    o_misalign = 1'b0;
    case (i_req_size)
      SZ_WORD: begin
        o_be       = 4'b1111;
        o_misalign = (i_req_off != 2'b00);
      end
      SZ_HALF: begin
        o_be       = 4'b0011 << i_req_off;
        o_misalign = i_req_off[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ldata = {24'd0, w_rsh[7:0]};
    case (i_rsp_size)
      SZ_WORD: o_ldata = w_rsh;
      SZ_HALF: o_ldata = {16'd0, w_rsh[15:0]};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// mem_access_unit: execute-to-writeback stage issuing single data-memory accesses.
// Optional bus timeout enabled by defining MEM_ACCESS_TIMEOUT_EN. Revision 1.0.
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_ans,
  input  logic [31:0] ex_bdata,
  input  logic        ex_dm_en,
  input  logic        ex_dm_rw,
  input  logic [1:0]  ex_loadsize,
  input  logic        ex_seldmresult,
  input  logic [4:0]  ex_rw,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rw,
  output logic        misalign,
  output logic        timeout
);

  state_t      r_state, w_state_nx;
  logic [31:0] r_addr;
  size_t       r_size;
  logic        r_seldm;
  logic [4:0]  r_rw;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_wb_valid, r_misalign, r_timeout;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rw;

  size_t       w_ex_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ldata;
  logic        w_misal, w_to_hit;

  logic        w_mem_req, w_mem_we, w_wb_valid, w_misal_p, w_to_p, w_capture;
  logic [31:0] w_mem_wdata, w_wb_data;
  logic [3:0]  w_mem_be;
  logic [4:0]  w_wb_rw;

  assign w_ex_size = decode_size(ex_loadsize);

  mem_lane_align u_lane (
    .i_req_off  (ex_ans[1:0]),
    .i_req_size (w_ex_size),
    .i_bdata    (ex_bdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_misalign (w_misal),
    .i_rsp_off  (r_addr[1:0]),
    .i_rsp_size (r_size),
    .i_rdata    (mem_rdata),
    .o_ldata    (w_ldata)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || r_state != ST_BUSY) r_cnt <= 4'd0;
    else                             r_cnt <= r_cnt + 4'd1;
  end

  // An ack arriving in the final allowed cycle takes priority over the timeout.
  assign w_to_hit = (r_state == ST_BUSY) && (r_cnt == 4'(TIMEOUT_CYCLES - 1)) && !mem_ack;
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (ex_valid && ex_dm_en && !w_misal) w_state_nx = ST_BUSY;
      ST_BUSY: if (mem_ack || w_to_hit)              w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wdata = r_mem_wdata;
    w_mem_be    = r_mem_be;
    w_wb_valid  = 1'b0;
    w_wb_data   = r_wb_data;
    w_wb_rw     = r_wb_rw;
    w_misal_p   = 1'b0;
    w_to_p      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ex_valid && !ex_dm_en) begin
          w_wb_valid = 1'b1;
          w_wb_data  = ex_ans;
          w_wb_rw    = ex_rw;
        end else if (ex_valid && w_misal) begin
          w_wb_valid = 1'b1;
          w_wb_data  = ex_ans;
          w_wb_rw    = 5'd0;
          w_misal_p  = 1'b1;
        end else if (ex_valid) begin
          w_capture   = 1'b1;
          w_mem_req   = 1'b1;
          w_mem_we    = ex_dm_rw;
          w_mem_wdata = w_wdata;
          w_mem_be    = w_be;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          w_wb_valid = 1'b1;
          w_wb_data  = r_seldm ? w_ldata : r_addr;
          w_wb_rw    = r_mem_we ? 5'd0 : r_rw;
        end else if (w_to_hit) begin
          w_wb_valid = 1'b1;
          w_wb_data  = r_addr;
          w_wb_rw    = 5'd0;
          w_to_p     = 1'b1;
        end else begin
          w_mem_req = 1'b1;
          w_mem_we  = r_mem_we;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= 32'd0;
      r_size      <= SZ_BYTE;
      r_seldm     <= 1'b0;
      r_rw        <= 5'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'b0000;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= 32'd0;
      r_wb_rw     <= 5'd0;
      r_misalign  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr  <= ex_ans;
        r_size  <= w_ex_size;
        r_seldm <= ex_seldmresult;
        r_rw    <= ex_rw;
      end
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_wdata <= w_mem_wdata;
      r_mem_be    <= w_mem_be;
      r_wb_valid  <= w_wb_valid;
      r_wb_data   <= w_wb_data;
      r_wb_rw     <= w_wb_rw;
      r_misalign  <= w_misal_p;
      r_timeout   <= w_to_p;
    end
  end

  assign stall     = (r_state == ST_BUSY);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign wb_valid  = r_wb_valid;
  assign wb_data   = r_wb_data;
  assign wb_rw     = r_wb_rw;
  assign misalign  = r_misalign;
  assign timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed stimulus with a queue scoreboard on the writeback port.
// Revision 1.0 - initial release.
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_ans = 32'd0;
  logic [31:0] ex_bdata = 32'd0;
  logic        ex_dm_en = 1'b0;
  logic        ex_dm_rw = 1'b0;
  logic [1:0]  ex_loadsize = 2'b00;
  logic        ex_seldmresult = 1'b0;
  logic [4:0]  ex_rw = 5'd0;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rw;
  logic        misalign, timeout;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rw;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ans(ex_ans), .ex_bdata(ex_bdata),
    .ex_dm_en(ex_dm_en), .ex_dm_rw(ex_dm_rw), .ex_loadsize(ex_loadsize),
    .ex_seldmresult(ex_seldmresult), .ex_rw(ex_rw), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rw(wb_rw), .misalign(misalign), .timeout(timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_wb(input logic [31:0] d, input logic cd, input logic [4:0] rw,
                           input logic mis, input logic to);
    exp_t e;
    e.data = d; e.chk_data = cd; e.rw = rw; e.mis = mis; e.to = to;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ans, input logic [31:0] bd, input logic dm_en,
                       input logic wr, input logic [1:0] ls, input logic sel,
                       input logic [4:0] rd);
    ex_ans = ans; ex_bdata = bd; ex_dm_en = dm_en; ex_dm_rw = wr;
    ex_loadsize = ls; ex_seldmresult = sel; ex_rw = rd; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_dm_en = 1'b0;
  endtask

  // Scoreboard monitor: every writeback beat must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb actual=valid required=none data=%h rw=%0d", wb_data, wb_rw);
        end else begin
          e = sb.pop_front();
          if (e.chk_data) chk("wb_data", wb_data, e.data);
          chk("wb_rw", {27'd0, wb_rw}, {27'd0, e.rw});
          chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
          chk("timeout", {31'd0, timeout}, {31'd0, e.to});
        end
      end else if (misalign || timeout) begin
        checks++; errors++;
        $display("FAIL stray_pulse actual=mis%0d/to%0d required=0/0", misalign, timeout);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_wbvalid", {31'd0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU pass-through
    expect_wb(32'h0000_1234, 1'b1, 5'd5, 1'b0, 1'b0);
    issue(32'h0000_1234, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd5);
    @(negedge clk);
    chk("alu_req", {31'd0, mem_req}, 32'd0);

    // Byte store at 0x103, ack in third busy cycle
    expect_wb(32'h0000_0103, 1'b1, 5'd0, 1'b0, 1'b0);
    issue(32'h0000_0103, 32'h0000_00AB, 1'b1, 1'b1, 2'b00, 1'b0, 5'd9);
    @(negedge clk);
    chk("bs_req", {31'd0, mem_req}, 32'd1);
    chk("bs_we", {31'd0, mem_we}, 32'd1);
    chk("bs_addr", mem_addr, 32'h0000_0100);
    chk("bs_be", {28'd0, mem_be}, 32'h8);
    chk("bs_wdata", mem_wdata, 32'hAB00_0000);
    chk("bs_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bs_addr_hold", mem_addr, 32'h0000_0100);
    chk("bs_wdata_hold", mem_wdata, 32'hAB00_0000);
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("bs_req_c3", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("bs_stall_done", {31'd0, stall}, 32'd0);
    chk("bs_req_done", {31'd0, mem_req}, 32'd0);

    // Half load at 0x202
    expect_wb(32'h0000_BEEF, 1'b1, 5'd7, 1'b0, 1'b0);
    issue(32'h0000_0202, 32'd0, 1'b1, 1'b0, 2'b01, 1'b1, 5'd7);
    @(negedge clk);
    chk("hl_be", {28'd0, mem_be}, 32'hC);
    chk("hl_we", {31'd0, mem_we}, 32'd0);
    chk("hl_addr", mem_addr, 32'h0000_0200);
    mem_rdata = 32'hBEEF_1234; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;

    // Byte load at 0x501 picks lane 1
    expect_wb(32'h0000_0033, 1'b1, 5'd4, 1'b0, 1'b0);
    issue(32'h0000_0501, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1, 5'd4);
    mem_rdata = 32'h1122_3344; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;

    // Word load; loadsize 11 decodes as word
    expect_wb(32'hDEAD_BEEF, 1'b1, 5'd3, 1'b0, 1'b0);
    issue(32'h0000_0400, 32'd0, 1'b1, 1'b0, 2'b11, 1'b1, 5'd3);
    @(negedge clk);
    chk("wl_be", {28'd0, mem_be}, 32'hF);
    mem_rdata = 32'hDEAD_BEEF; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;

    // Half store at 0x602
    expect_wb(32'h0000_0602, 1'b1, 5'd0, 1'b0, 1'b0);
    issue(32'h0000_0602, 32'h0000_5A5A, 1'b1, 1'b1, 2'b01, 1'b0, 5'd2);
    @(negedge clk);
    chk("hs_be", {28'd0, mem_be}, 32'hC);
    chk("hs_wdata", mem_wdata, 32'h5A5A_0000);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;

    // Misaligned word and half accesses
    expect_wb(32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    issue(32'h0000_0301, 32'd0, 1'b1, 1'b0, 2'b10, 1'b1, 5'd6);
    @(negedge clk);
    chk("mw_req", {31'd0, mem_req}, 32'd0);
    chk("mw_stall", {31'd0, stall}, 32'd0);
    expect_wb(32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    issue(32'h0000_0203, 32'd0, 1'b1, 1'b1, 2'b01, 1'b0, 5'd6);
    @(negedge clk);
    chk("mh_req", {31'd0, mem_req}, 32'd0);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_stall", {31'd0, stall}, 32'd0);

    // Reset in second busy cycle abandons the access
    issue(32'h0000_0700, 32'd0, 1'b1, 1'b0, 2'b10, 1'b1, 5'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rb_req", {31'd0, mem_req}, 32'd0);
    chk("rb_stall", {31'd0, stall}, 32'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    expect_wb(32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    issue(32'h0000_0800, 32'd0, 1'b1, 1'b0, 2'b10, 1'b1, 5'd8);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("to_req_c%0d", i), {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_stall", {31'd0, stall}, 32'd0);
    expect_wb(32'h1234_5678, 1'b1, 5'd10, 1'b0, 1'b0);
    issue(32'h0000_0900, 32'd0, 1'b1, 1'b0, 2'b10, 1'b1, 5'd10);
    repeat (15) begin @(posedge clk); #1; end
    mem_rdata = 32'h1234_5678; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
`else
    issue(32'h0000_0800, 32'd0, 1'b1, 1'b0, 2'b10, 1'b1, 5'd8);
    repeat (39) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("nto_req_c40", {31'd0, mem_req}, 32'd1);
    chk("nto_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
- REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
- REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
- REQ-003 SHALL have port ex_valid  input  1  an execute-stage result is presented this cycle.
- REQ-004 SHALL have port ex_ans  input  32  ALU result; memory byte address when ex_dm_en=1.
- REQ-005 SHALL have port ex_bdata  input  32  store data, already zero-extended to its size.
- REQ-006 SHALL have port ex_dm_en  input  1  access data memory.
- REQ-007 SHALL have port ex_dm_rw  input  1  0 read, 1 write.
- REQ-008 SHALL have port ex_loadsize  input  2  bit1=1 word; else bit0=1 half; else byte.
- REQ-009 SHALL have port ex_seldmresult  input  1  1 selects memory data for writeback, 0 selects ex_ans.
- REQ-010 SHALL have port ex_rw  input  5  destination register.
- REQ-011 SHALL have port stall  output  1  upstream holds its outputs while high.
- REQ-012 SHALL have ports mem_req/mem_we  output  1 each  bus request and write strobe.
- REQ-013 SHALL have ports mem_addr/mem_wdata  output  32 each  word-aligned address ({ex_ans[31:2],2'b00}) and lane-shifted data.
- REQ-014 SHALL have port mem_be  output  4  byte enables.
- REQ-015 SHALL have ports mem_rdata (input, 32) and mem_ack (input, 1)  read data and completion.
- REQ-016 SHALL have ports wb_valid (1), wb_data (32), wb_rw (5)  outputs  writeback result.
- REQ-017 SHALL have ports misalign and timeout  output  1 each  single-cycle error pulses.

Function
- REQ-018 SHALL implement FSM IDLE/BUSY; inputs sampled only in IDLE; stall = (state==BUSY), registered.
- REQ-019 In IDLE with ex_valid=1, ex_dm_en=0: next cycle wb_valid=1, wb_data=ex_ans, wb_rw=ex_rw (latency 1); no bus activity.
- REQ-020 In IDLE with ex_valid=1, ex_dm_en=1, aligned: capture address/data/size/rw/seldmresult, enter BUSY; mem_req=1 from next cycle.
- REQ-021 mem_be SHALL be 1111 for word, 0011<<addr[1:0] for half, 0001<<addr[1:0] for byte; mem_wdata = ex_bdata<<(8*addr[1:0]); mem_we=captured ex_dm_rw.
- REQ-022 In BUSY, mem_req/mem_we/mem_addr/mem_wdata/mem_be SHALL be held stable until the mem_ack cycle; mem_req drops the cycle after ack.
- REQ-023 On mem_ack in BUSY: next cycle wb_valid=1, state IDLE, stall=0; load data = mem_rdata>>(8*addr[1:0]), zero-extended to byte/half/word; wb_data = seldmresult ? load data : address; wb_rw = captured rw for loads, 0 for stores.
- REQ-024 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus access, stay IDLE; next cycle misalign=1, wb_valid=1, wb_rw=0.
- REQ-025 mem_ack while IDLE SHALL be ignored; wb_valid is 0 in every cycle not named above.

Reset
- REQ-026 On reset: state IDLE; stall, mem_req, mem_we, wb_valid, misalign, timeout = 0; mem_addr, mem_wdata, wb_data = 0; mem_be = 0000; wb_rw = 0; timeout counter = 0.
- REQ-027 Reset during BUSY SHALL abandon the access: mem_req=0 the next cycle, no wb_valid for it.

Configuration
- REQ-028 With MEM_ACCESS_TIMEOUT_EN defined: 4-bit counter counts BUSY cycles; after 16 BUSY cycles without mem_ack, drop mem_req, return IDLE, next cycle timeout=1, wb_valid=1, wb_rw=0. Ack in 16th cycle wins.
- REQ-029 Without MEM_ACCESS_TIMEOUT_EN: no counter, BUSY waits indefinitely, timeout tied 0.

Structure
- REQ-030 Package mem_access_pkg SHALL hold the state enum, loadsize encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and TIMEOUT_CYCLES=16.
- REQ-031 Lane logic (byte enables, store shift, load extract, misalign detect) SHALL be combinational sub-module mem_lane_align.

Verification
- REQ-032 ALU pass-through: ex_ans=0x0000_1234, ex_rw=5, dm_en=0 -> next cycle wb_valid=1, wb_data=0x1234, wb_rw=5, mem_req=0.
- REQ-033 Byte store: addr=0x103, bdata=0xAB -> mem_addr=0x100, mem_be=1000, mem_wdata=0xAB00_0000; ack after 3 cycles -> wb_valid=1, wb_rw=0, stall low next cycle.
- REQ-034 Half load: addr=0x202, rdata=0xBEEF_1234, seldmresult=1, rw=7 -> mem_be=1100, wb_data=0x0000_BEEF, wb_rw=7.
- REQ-035 Misaligned word load at 0x301 -> no mem_req, misalign pulse, wb_valid=1, wb_rw=0.
- REQ-036 Reset asserted in 2nd BUSY cycle -> mem_req=0, stall=0 next cycle, no wb_valid.
- REQ-037 With MEM_ACCESS_TIMEOUT_EN, no ack for 16 cycles -> mem_req drops, timeout=1 one cycle, wb_rw=0; without macro, mem_req still high at cycle 40.
